// File: rtl/ice_sl_arbiter.sv
// Single-frame arbiter for the ICE slave output bus: round-robin or fixed priority,
// per-frame watchdog with requester lockout. Optional stats counters under ICE_ARB_STATS_EN.
module ice_sl_arbiter #(
  parameter int NUM_DEV    = 7,
  parameter int IDX_W      = 3,
  parameter int TIMEOUT_W  = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_DEV-1:0]   sl_arb_request,
  input  logic                 sl_latch_tail,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic [NUM_DEV-1:0]   sl_arb_grant,
  output logic                 arb_busy,
  output logic [IDX_W-1:0]     owner_idx,
  output logic                 timeout_evt,
  output logic [NUM_DEV-1:0]   lockout
`ifdef ICE_ARB_STATS_EN
  ,
  input  logic [IDX_W-1:0]     stat_sel,
  input  logic                 stat_clear,
  output logic [15:0]          stat_grants,
  output logic [7:0]           stat_timeouts
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]           r_state;
  logic [NUM_DEV-1:0]   r_grant;
  logic [IDX_W-1:0]     r_owner;
  logic [TIMEOUT_W-1:0] r_wdog;
  logic                 r_tevt;
  logic [NUM_DEV-1:0]   r_lock;

  logic [NUM_DEV-1:0]   w_elig;
  logic [IDX_W:0]       w_pick;
  logic                 w_found;
  logic [IDX_W-1:0]     w_win;
  logic                 w_to;
  logic                 w_start;
  logic                 w_revoke;
  logic [NUM_DEV-1:0]   w_lock_next;

  // Returns {found, index}; round-robin searches upward from the slot after last.
  function automatic logic [IDX_W:0] f_pick(input logic [NUM_DEV-1:0] e,
                                            input logic [IDX_W-1:0]   last);
    logic             found;
    logic [IDX_W-1:0] win;
    int unsigned      cand;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NUM_DEV; k++) begin
      if (FIXED_PRIO != 0) cand = k;
      else                 cand = (32'(last) + k + 1) % NUM_DEV;
      if (!found && e[IDX_W'(cand)]) begin
        found = 1'b1;
        win   = IDX_W'(cand);
      end
    end
    return {found, win};
  endfunction

  always_comb begin
    w_elig   = sl_arb_request & ~r_lock;
    w_pick   = f_pick(w_elig, r_owner);
    w_found  = w_pick[IDX_W];
    w_win    = w_pick[IDX_W-1:0];
    w_to     = (timeout_limit != '0) && (r_wdog == timeout_limit - 1'b1);
    w_start  = (r_state == S_IDLE) && w_found;
    // Tail and abandonment both outrank the watchdog.
    w_revoke = (r_state == S_GRANT) && !sl_latch_tail && sl_arb_request[r_owner] && w_to;
    w_lock_next = r_lock & sl_arb_request;
    if (w_revoke) w_lock_next[r_owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_owner <= IDX_W'(NUM_DEV - 1);
      r_wdog  <= '0;
      r_tevt  <= 1'b0;
      r_lock  <= '0;
    end else begin
      r_tevt <= 1'b0;
      r_lock <= w_lock_next;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_grant <= NUM_DEV'(1) << w_win;
            r_owner <= w_win;
            r_wdog  <= '0;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (r_wdog != '1) r_wdog <= r_wdog + 1'b1;
          if (sl_latch_tail || !sl_arb_request[r_owner] || w_to) begin
            r_grant <= '0;
            r_state <= S_RELEASE;
            r_tevt  <= w_revoke;
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sl_arb_grant = r_grant;
  assign arb_busy     = (r_state == S_GRANT);
  assign owner_idx    = r_owner;
  assign timeout_evt  = r_tevt;
  assign lockout      = r_lock;

`ifdef ICE_ARB_STATS_EN
  logic [15:0] r_sg [NUM_DEV];
  logic [7:0]  r_st [NUM_DEV];
  logic [15:0] r_stat_grants;
  logic [7:0]  r_stat_timeouts;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (rst || stat_clear) begin
        r_sg[i] <= '0;
        r_st[i] <= '0;
      end else begin
        if (w_start && (w_win == IDX_W'(i)) && (r_sg[i] != '1)) r_sg[i] <= r_sg[i] + 1'b1;
        if (w_revoke && (r_owner == IDX_W'(i)) && (r_st[i] != '1)) r_st[i] <= r_st[i] + 1'b1;
      end
    end
    if (rst || stat_clear || (32'(stat_sel) >= NUM_DEV)) begin
      r_stat_grants   <= '0;
      r_stat_timeouts <= '0;
    end else begin
      r_stat_grants   <= r_sg[stat_sel];
      r_stat_timeouts <= r_st[stat_sel];
    end
  end

  assign stat_grants   = r_stat_grants;
  assign stat_timeouts = r_stat_timeouts;
`endif

endmodule

// File: tb/tb_ice_sl_arbiter.sv
// Directed bench for ice_sl_arbiter: a round-robin instance and a fixed-priority instance.
module tb_ice_sl_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  req, freq;
  logic        tail, ftail;
  logic [15:0] tlim;
  logic [6:0]  grant, fgrant, lock, flock;
  logic        busy, fbusy, tevt, ftevt;
  logic [2:0]  owner, fowner;
  int          errors = 0;
  int          checks = 0;
`ifdef ICE_ARB_STATS_EN
  logic [2:0]  ssel;
  logic        sclr;
  logic [15:0] sg, fsg;
  logic [7:0]  st, fst;
`endif

  always #5 clk = ~clk;

  ice_sl_arbiter #(.NUM_DEV(7), .IDX_W(3), .TIMEOUT_W(16), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst), .sl_arb_request(req), .sl_latch_tail(tail),
    .timeout_limit(tlim), .sl_arb_grant(grant), .arb_busy(busy),
    .owner_idx(owner), .timeout_evt(tevt), .lockout(lock)
`ifdef ICE_ARB_STATS_EN
    , .stat_sel(ssel), .stat_clear(sclr), .stat_grants(sg), .stat_timeouts(st)
`endif
  );

  ice_sl_arbiter #(.NUM_DEV(7), .IDX_W(3), .TIMEOUT_W(16), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst), .sl_arb_request(freq), .sl_latch_tail(ftail),
    .timeout_limit(16'd0), .sl_arb_grant(fgrant), .arb_busy(fbusy),
    .owner_idx(fowner), .timeout_evt(ftevt), .lockout(flock)
`ifdef ICE_ARB_STATS_EN
    , .stat_sel(ssel), .stat_clear(sclr), .stat_grants(fsg), .stat_timeouts(fst)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (grant !== 7'b0) begin errors++; $display("FAIL reset_grant got=%b exp=0000000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (owner !== 3'd6) begin errors++; $display("FAIL reset_owner got=%0d exp=6", owner); end
    checks++; if (tevt !== 1'b0) begin errors++; $display("FAIL reset_tevt got=%b exp=0", tevt); end
    checks++; if (lock !== 7'b0) begin errors++; $display("FAIL reset_lock got=%b exp=0000000", lock); end
  endtask

  task automatic test_basic();
    req = 7'b0000001; tick();
    checks++; if (grant !== 7'b0000001) begin errors++; $display("FAIL basic_grant got=%b exp=0000001", grant); end
    checks++; if (owner !== 3'd0) begin errors++; $display("FAIL basic_owner got=%0d exp=0", owner); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    tail = 1'b1; tick(); tail = 1'b0;
    checks++; if (grant !== 7'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_release got=%b/%b exp=0000000/0", grant, busy); end
    tick();
    checks++; if (grant !== 7'b0) begin errors++; $display("FAIL basic_idle got=%b exp=0000000", grant); end
    tick();
    checks++; if (grant !== 7'b0000001) begin errors++; $display("FAIL basic_regrant got=%b exp=0000001", grant); end
    req = 7'b0; tick();
    checks++; if (grant !== 7'b0 || tevt !== 1'b0) begin errors++; $display("FAIL basic_abandon got=%b/%b exp=0000000/0", grant, tevt); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [6:0] exp;
    rst = 1'b1; req = 7'b1111111; tick(); rst = 1'b0;
    for (int g = 0; g < 8; g++) begin
      exp = 7'b0000001 << (g % 7);
      for (int c = 0; c < 5; c++) begin
        tick();
        checks++; if (grant !== exp) begin errors++; $display("FAIL rr_grant%0d_c%0d got=%b exp=%b", g, c, grant, exp); end
        checks++; if ($countones(grant) > 1) begin errors++; $display("FAIL rr_onehot got=%b exp=at most one bit", grant); end
      end
      tail = 1'b1; tick(); tail = 1'b0;
      checks++; if (grant !== 7'b0) begin errors++; $display("FAIL rr_release%0d got=%b exp=0000000", g, grant); end
      tick();
      checks++; if (grant !== 7'b0) begin errors++; $display("FAIL rr_idle%0d got=%b exp=0000000", g, grant); end
    end
    req = 7'b0; tick(); tick(); tick();
  endtask

  task automatic test_fixed_prio();
    freq = 7'b1010100; tick();
    for (int f = 0; f < 3; f++) begin
      checks++; if (fgrant !== 7'b0000100) begin errors++; $display("FAIL fp_dev2_%0d got=%b exp=0000100", f, fgrant); end
      if (f < 2) begin
        ftail = 1'b1; tick(); ftail = 1'b0; tick(); tick();
      end
    end
    freq = 7'b1010000; tick();
    checks++; if (fgrant !== 7'b0) begin errors++; $display("FAIL fp_abandon got=%b exp=0000000", fgrant); end
    tick(); tick();
    checks++; if (fgrant !== 7'b0010000) begin errors++; $display("FAIL fp_dev4 got=%b exp=0010000", fgrant); end
    checks++; if (fowner !== 3'd4) begin errors++; $display("FAIL fp_owner got=%0d exp=4", fowner); end
    freq = 7'b0; tick(); tick();
  endtask

  task automatic test_timeout();
    rst = 1'b1; tick(); rst = 1'b0;
    tlim = 16'd10; req = 7'b0001000; tick();
    checks++; if (grant !== 7'b0001000) begin errors++; $display("FAIL to_grant got=%b exp=0001000", grant); end
    for (int c = 2; c <= 10; c++) begin
      tick();
      checks++; if (grant !== 7'b0001000 || tevt !== 1'b0) begin errors++; $display("FAIL to_hold_c%0d got=%b/%b exp=0001000/0", c, grant, tevt); end
    end
    tick();
    checks++; if (grant !== 7'b0) begin errors++; $display("FAIL to_revoke got=%b exp=0000000", grant); end
    checks++; if (tevt !== 1'b1) begin errors++; $display("FAIL to_evt got=%b exp=1", tevt); end
    checks++; if (lock !== 7'b0001000) begin errors++; $display("FAIL to_lock got=%b exp=0001000", lock); end
    tick();
    checks++; if (tevt !== 1'b0) begin errors++; $display("FAIL to_evt_pulse got=%b exp=0", tevt); end
    tick();
    checks++; if (grant !== 7'b0) begin errors++; $display("FAIL to_locked_alone got=%b exp=0000000", grant); end
    req = 7'b0101000; tick();
    checks++; if (grant !== 7'b0100000 || owner !== 3'd5) begin errors++; $display("FAIL to_skip got=%b/%0d exp=0100000/5", grant, owner); end
    req = 7'b0100000; tick();
    checks++; if (lock !== 7'b0) begin errors++; $display("FAIL to_lock_clear got=%b exp=0000000", lock); end
    req = 7'b0001000; tick(); tick(); tick();
    checks++; if (grant !== 7'b0001000) begin errors++; $display("FAIL to_regrant got=%b exp=0001000", grant); end
    req = 7'b0; tick(); tick();
  endtask

  task automatic test_tail_timeout();
    tlim = 16'd4; req = 7'b0000010;
    tick(); tick(); tick(); tick();
    checks++; if (grant !== 7'b0000010 || owner !== 3'd1) begin errors++; $display("FAIL tt_hold got=%b/%0d exp=0000010/1", grant, owner); end
    tail = 1'b1; tick(); tail = 1'b0;
    checks++; if (grant !== 7'b0 || tevt !== 1'b0) begin errors++; $display("FAIL tt_release got=%b/%b exp=0000000/0", grant, tevt); end
    checks++; if (lock !== 7'b0) begin errors++; $display("FAIL tt_lock got=%b exp=0000000", lock); end
    tick();
    checks++; if (tevt !== 1'b0) begin errors++; $display("FAIL tt_evt_late got=%b exp=0", tevt); end
    req = 7'b0; tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    tlim = 16'd2; req = 7'b0000001; tick(); tick(); tick();
    checks++; if (lock !== 7'b0000001) begin errors++; $display("FAIL rm_lock_set got=%b exp=0000001", lock); end
    req = 7'b0000101; tick(); tick();
    checks++; if (grant !== 7'b0000100) begin errors++; $display("FAIL rm_grant got=%b exp=0000100", grant); end
    tick();
    rst = 1'b1; tick();
    checks++; if (grant !== 7'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_grant_clr got=%b/%b exp=0000000/0", grant, busy); end
    checks++; if (owner !== 3'd6) begin errors++; $display("FAIL rm_owner got=%0d exp=6", owner); end
    checks++; if (lock !== 7'b0 || tevt !== 1'b0) begin errors++; $display("FAIL rm_lock_evt got=%b/%b exp=0000000/0", lock, tevt); end
`ifdef ICE_ARB_STATS_EN
    for (int d = 0; d < 7; d++) begin
      ssel = 3'(d); tick();
      checks++; if (sg !== 16'd0) begin errors++; $display("FAIL rm_stat%0d got=%0d exp=0", d, sg); end
    end
`endif
    rst = 1'b0; req = 7'b0; tick();
  endtask

  initial begin
    rst = 1'b1; req = '0; freq = '0; tail = 1'b0; ftail = 1'b0; tlim = '0;
`ifdef ICE_ARB_STATS_EN
    ssel = '0; sclr = 1'b0;
`endif
    test_reset();
    test_basic();
    test_round_robin();
    test_fixed_prio();
    test_timeout();
    test_tail_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit got=expired exp=bench complete");
    $fatal(1, "time limit");
  end
endmodule
